mac_accum: RTL

- Sequential accumulation stage directly downstream of the Booth multiplier `mul`.
- Consumes a stream of signed 2*WIDTH-bit products over a valid/ready handshake.
- Sums LEN products, or fewer if terminated early by in_last, into an ACC_WIDTH accumulator.
- Presents the dot-product result on an output valid/ready port, with an overflow flag.

---
 rtl/mac_accum.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mac_accum.sv
// Multiply-accumulate back end: sums a frame of signed products from the Booth
// multiplier and hands the frame result downstream over a valid/ready port.
module mac_accum #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24,
  parameter int LEN       = 4,
  parameter int SAT       = 1,
  localparam int CNT_W    = $clog2(LEN + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*WIDTH-1:0]     in_prod,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH-1:0]   out_sum,
  output logic [CNT_W-1:0]       out_cnt,
  output logic                   out_ovf
);

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam int                 EXT_W   = ACC_WIDTH + 1 - 2 * WIDTH;
  localparam logic [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH - 1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH - 1){1'b0}}};
  localparam logic [CNT_W-1:0]   CNT_LEN = CNT_W'(LEN);

  state_t                 state_reg, state_next;
  logic [ACC_WIDTH-1:0]   acc_reg, acc_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic                   ovf_reg, ovf_next;
  logic [ACC_WIDTH-1:0]   out_sum_reg, out_sum_next;
  logic [CNT_W-1:0]       out_cnt_reg, out_cnt_next;
  logic                   out_ovf_reg, out_ovf_next;

  logic [ACC_WIDTH:0]     prod_ext;
  logic [ACC_WIDTH:0]     sum_wide;
  logic                   add_ovf;
  logic [ACC_WIDTH-1:0]   sum_res;
  logic [CNT_W-1:0]       cnt_inc;
  logic                   ovf_upd;
  logic                   frame_end;

  // One guard bit above the accumulator exposes signed overflow directly.
  always_comb begin
    prod_ext = {{EXT_W{in_prod[2*WIDTH-1]}}, in_prod};
    sum_wide = {acc_reg[ACC_WIDTH-1], acc_reg} + prod_ext;
    add_ovf  = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
    if (add_ovf && (SAT != 0)) begin
      sum_res = sum_wide[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
    end else begin
      sum_res = sum_wide[ACC_WIDTH-1:0];
    end
    cnt_inc   = cnt_reg + CNT_W'(1);
    ovf_upd   = ovf_reg | add_ovf;
    frame_end = (cnt_inc == CNT_LEN) || in_last;
  end

  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    cnt_next     = cnt_reg;
    ovf_next     = ovf_reg;
    out_sum_next = out_sum_reg;
    out_cnt_next = out_cnt_reg;
    out_ovf_next = out_ovf_reg;
    in_ready     = (state_reg == ST_ACC);
    out_valid    = (state_reg == ST_HOLD);

    if (clr) begin
      // Frame abort wins over any handshake offered in the same cycle.
      state_next = ST_ACC;
      acc_next   = '0;
      cnt_next   = '0;
      ovf_next   = 1'b0;
    end else begin
      case (state_reg)
        ST_ACC: begin
          if (in_valid) begin
            acc_next = sum_res;
            cnt_next = cnt_inc;
            ovf_next = ovf_upd;
            if (frame_end) begin
              out_sum_next = sum_res;
              out_cnt_next = cnt_inc;
              out_ovf_next = ovf_upd;
              state_next   = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            acc_next   = '0;
            cnt_next   = '0;
            ovf_next   = 1'b0;
            state_next = ST_ACC;
          end
        end
        default: begin
          state_next = ST_ACC;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_ACC;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      ovf_reg     <= 1'b0;
      out_sum_reg <= '0;
      out_cnt_reg <= '0;
      out_ovf_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      cnt_reg     <= cnt_next;
      ovf_reg     <= ovf_next;
      out_sum_reg <= out_sum_next;
      out_cnt_reg <= out_cnt_next;
      out_ovf_reg <= out_ovf_next;
    end
  end

  assign out_sum = out_sum_reg;
  assign out_cnt = out_cnt_reg;
  assign out_ovf = out_ovf_reg;

endmodule
